// File: rtl/pwm_dc_sequencer.sv
// pwm_dc_sequencer
//   Bus-programmable duty-cycle streamer feeding the PWM block's external
//   duty-cycle inputs. The host fills a sample FIFO over a simple register
//   bus. A programmable interval timer pops one sample per tick and presents
//   it on o_DC together with a one-cycle o_valid_DC strobe. In loop mode each
//   popped sample is re-queued at the tail, so the buffer replays forever.
//
//   Ports:
//     clk_i       single clock
//     rst_i       asynchronous active-high reset
//     re_i/we_i   bus read / write enables (write = we_i & ~re_i)
//     addr_i      byte register address
//     wdata_i     write data
//     be_i        byte enables (ignored, full-word writes only)
//     rdata_o     combinational read data
//     o_DC        current duty-cycle sample (holds between strobes)
//     o_valid_DC  one-cycle strobe qualifying o_DC
//     o_irq       low-watermark interrupt (level)
//
//   Registers: 0x00 ctrl, 0x04 interval, 0x08 data, 0x0C status,
//              0x10 prescale (only with PWM_DC_SEQ_PRESCALE_EN defined).
//
//   Optional feature macro: PWM_DC_SEQ_PRESCALE_EN adds a prescaler so the
//   tick period becomes (prescale+1)*max(interval,1) cycles.
module pwm_dc_sequencer #(
   parameter int DEPTH = 16,
   parameter int DW    = 16,
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          re_i,
   input  logic          we_i,
   input  logic [7:0]    addr_i,
   input  logic [31:0]   wdata_i,
   input  logic [3:0]    be_i,
   output logic [31:0]   rdata_o,
   output logic [DW-1:0] o_DC,
   output logic          o_valid_DC,
   output logic          o_irq
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic          run_q, loop_q, irq_en_q;
   logic [7:0]    thr_q;
   logic [15:0]   ivl_q;
   logic          ovf_q, udf_q;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] cnt_q;
   logic [15:0]   tick_cnt_q;
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] dc_p1;
   logic          vld_p1;
   logic          irq_q;

   logic wr_en, ctrl_wr, ivl_wr, data_wr, stat_wr, flush;
   logic [15:0] ivl_eff;
   logic tick_hit, pre_tc, tick, cnt_clr;
   logic empty, full, pop, loop_pop, push_req, push_ok, ovf_set, udf_set;

   // be_i is intentionally ignored; only full-word writes are supported
   logic unused_bits;
   assign unused_bits = &{1'b0, be_i, wdata_i};

   always_comb begin
      wr_en    = we_i & ~re_i;
      ctrl_wr  = wr_en && (addr_i == 8'h00);
      ivl_wr   = wr_en && (addr_i == 8'h04);
      data_wr  = wr_en && (addr_i == 8'h08);
      stat_wr  = wr_en && (addr_i == 8'h0C);
      flush    = ctrl_wr & wdata_i[3];
      // interval 0 behaves like interval 1
      ivl_eff  = (ivl_q == 16'd0) ? 16'd1 : ivl_q;
      tick_hit = (tick_cnt_q == ivl_eff - 16'd1);
      // timers restart whenever run is (being) cleared or on flush
      cnt_clr  = flush | ~run_q | (ctrl_wr & ~wdata_i[0]);
      tick     = run_q & pre_tc & tick_hit;
      empty    = (cnt_q == '0);
      full     = (cnt_q == FULL_CNT);
      pop      = tick & ~empty & ~flush;
      loop_pop = pop & loop_q;
      udf_set  = tick & empty & ~flush;
      push_req = data_wr & ~flush;
      // fullness is judged on the start-of-cycle count, even with a pop
      push_ok  = push_req & ~loop_q & ~full;
      ovf_set  = push_req & (loop_q | full);
   end

`ifdef PWM_DC_SEQ_PRESCALE_EN
   logic [7:0] ps_q, ps_cnt_q;
   logic       ps_wr;

   assign ps_wr  = wr_en && (addr_i == 8'h10);
   assign pre_tc = (ps_cnt_q == ps_q);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ps_q     <= '0;
         ps_cnt_q <= '0;
      end else begin
         if (ps_wr) ps_q <= wdata_i[7:0];
         if (cnt_clr | pre_tc) ps_cnt_q <= '0;
         else                  ps_cnt_q <= ps_cnt_q + 8'd1;
      end
   end
`else
   assign pre_tc = 1'b1;
`endif

   // Sample storage is not reset; only pointers and count define validity.
   always_ff @(posedge clk_i) begin
      if (push_ok)       mem[wr_ptr_q] <= wdata_i[DW-1:0];
      else if (loop_pop) mem[wr_ptr_q] <= mem[rd_ptr_q];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         run_q      <= 1'b0;
         loop_q     <= 1'b0;
         irq_en_q   <= 1'b0;
         thr_q      <= '0;
         ivl_q      <= '0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         tick_cnt_q <= '0;
         dc_p1      <= '0;
         vld_p1     <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            run_q    <= wdata_i[0];
            loop_q   <= wdata_i[1];
            irq_en_q <= wdata_i[2];
            thr_q    <= wdata_i[15:8];
         end
         if (ivl_wr) ivl_q <= wdata_i[15:0];

         if (flush) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
         end else begin
            ovf_q <= ovf_set | (ovf_q & ~(stat_wr & wdata_i[18]));
            udf_q <= udf_set | (udf_q & ~(stat_wr & wdata_i[19]));
         end

         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
         end else begin
            if (pop)                 rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_ok | loop_pop)  wr_ptr_q <= wr_ptr_q + AW'(1);
            // loop pops re-queue the sample, so only stream pops drain
            if (push_ok && !(pop && !loop_q))      cnt_q <= cnt_q + CW'(1);
            else if (!push_ok && pop && !loop_q)   cnt_q <= cnt_q - CW'(1);
         end

         if (cnt_clr)     tick_cnt_q <= '0;
         else if (pre_tc) tick_cnt_q <= tick_hit ? 16'd0 : tick_cnt_q + 16'd1;

         // p0 -> p1: popped sample is presented one cycle after the tick
         vld_p1 <= pop;
         if (pop) dc_p1 <= mem[rd_ptr_q];

         irq_q <= irq_en_q & (32'(cnt_q) <= 32'(thr_q));
      end
   end

   assign o_DC       = dc_p1;
   assign o_valid_DC = vld_p1;
   assign o_irq      = irq_q;

   always_comb begin
      rdata_o = '0;
      case (addr_i)
         8'h00: begin
            rdata_o[0]    = run_q;
            rdata_o[1]    = loop_q;
            rdata_o[2]    = irq_en_q;
            rdata_o[15:8] = thr_q;
         end
         8'h04: rdata_o[15:0] = ivl_q;
         8'h0C: begin
            rdata_o[CW-1:0] = cnt_q;
            rdata_o[16]     = empty;
            rdata_o[17]     = full;
            rdata_o[18]     = ovf_q;
            rdata_o[19]     = udf_q;
         end
`ifdef PWM_DC_SEQ_PRESCALE_EN
         8'h10: rdata_o[7:0] = ps_q;
`endif
         default: rdata_o = '0;
      endcase
   end

endmodule

// File: tb/tb_pwm_dc_sequencer.sv
// tb_pwm_dc_sequencer
//   Self-checking bench for pwm_dc_sequencer. Expected strobe times, sample
//   order, FIFO occupancy and interrupt level are computed from the tick
//   period arithmetic and a sample queue held in the bench.
module tb_pwm_dc_sequencer;

   localparam int DEPTH = 16;
   localparam int DW    = 16;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        re_i = 1'b0;
   logic        we_i = 1'b0;
   logic [7:0]  addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic [3:0]  be_i = 4'hF;
   wire  [31:0] rdata_o;
   wire  [DW-1:0] o_DC;
   wire         o_valid_DC;
   wire         o_irq;

   int checks = 0;
   int failures = 0;
   logic [15:0] exp_dc = '0;
   logic [15:0] q[$];
   int ps_val = 0;

   pwm_dc_sequencer #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .re_i(re_i), .we_i(we_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i), .rdata_o(rdata_o),
      .o_DC(o_DC), .o_valid_DC(o_valid_DC), .o_irq(o_irq)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // write lands on the posedge following the call; returns on next negedge
   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      we_i = 1'b1; re_i = 1'b0; addr_i = a; wdata_i = d;
      @(negedge clk_i);
      we_i = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d);
      addr_i = a; re_i = 1'b1;
      #1;
      d = rdata_o;
      re_i = 1'b0;
   endtask

   function automatic int period(input int ivl);
      return (ps_val + 1) * ((ivl == 0) ? 1 : ivl);
   endfunction

   task automatic push_q();
      foreach (q[i]) wr(8'h08, {16'd0, q[i]});
   endtask

   // Observes M+2 cycles after run was written. Ticks fall in cycles that are
   // multiples of per; the k-th tick yields a strobe one cycle later with
   // q[k-1] (stream, while samples remain) or q[(k-1)%n] (loop). At cycle M
   // run is cleared, so the tick of cycle M still produces its strobe.
   task automatic monitor(input string tag, input int per, input bit lp, input int M,
                          input bit irq_on, input int thr, input logic [31:0] stop_ctrl);
      int n, k, ip, pops, cprev;
      bit ev, irq_exp;
      n = q.size();
      for (int j = 1; j <= M + 2; j++) begin
         ev = 1'b0;
         if (j >= per + 1 && j <= M + 1 && ((j - 1) % per) == 0) begin
            k = (j - 1) / per;
            if (lp || k <= n) begin
               ev = 1'b1;
               exp_dc = q[(k - 1) % n];
            end
         end
         ip = j - 1;
         pops = (ip >= 1) ? (ip - 1) / per : 0;
         cprev = lp ? n : ((pops >= n) ? 0 : n - pops);
         irq_exp = irq_on && (cprev <= thr);
         checks++;
         if (o_valid_DC !== ev) begin
            failures++;
            $display("FAIL %s valid cycle=%0d got=%0b exp=%0b", tag, j, o_valid_DC, ev);
         end
         checks++;
         if (o_DC !== exp_dc) begin
            failures++;
            $display("FAIL %s dc cycle=%0d got=%h exp=%h", tag, j, o_DC, exp_dc);
         end
         checks++;
         if (o_irq !== irq_exp) begin
            failures++;
            $display("FAIL %s irq cycle=%0d got=%0b exp=%0b", tag, j, o_irq, irq_exp);
         end
         if (j == M) begin
            we_i = 1'b1; addr_i = 8'h00; wdata_i = stop_ctrl;
         end
         if (j < M + 2) begin
            @(negedge clk_i);
            we_i = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic [7:0]  addrs [6];
      logic [31:0] exps  [6];
      addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h20};
      exps  = '{32'h0, 32'h0, 32'h0, 32'h0001_0000, 32'h0, 32'h0};
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (o_valid_DC !== 1'b0 || o_irq !== 1'b0 || o_DC !== 16'h0) begin
         failures++;
         $display("FAIL reset outputs got=%0b/%0b/%h exp=0/0/0000", o_valid_DC, o_irq, o_DC);
      end
      for (int i = 0; i < 6; i++) begin
         rd(addrs[i], d);
         checks++;
         if (d !== exps[i]) begin
            failures++;
            $display("FAIL reset reg%h got=%h exp=%h", addrs[i], d, exps[i]);
         end
      end
   endtask

   task automatic test_stream();
      logic [31:0] d;
      int n, ivl, per;
      for (int it = 0; it < 4; it++) begin
         wr(8'h00, 32'h8);
         q.delete();
         if (it == 0) begin
            ivl = 4;
            q.push_back(16'h0010); q.push_back(16'h0020); q.push_back(16'h0030);
         end else begin
            ivl = $urandom_range(0, 5);
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) q.push_back(16'($urandom));
         end
         wr(8'h04, ivl);
         rd(8'h04, d);
         checks++;
         if (d !== 32'(ivl)) begin
            failures++;
            $display("FAIL stream interval readback got=%h exp=%h", d, ivl);
         end
         push_q();
         wr(8'h00, 32'h1);
         per = period(ivl);
         monitor("stream", per, 1'b0, (q.size() + 2) * per + 1, 1'b0, 0, 32'h0);
         rd(8'h0C, d);
         checks++;
         if (d !== 32'h0009_0000) begin
            failures++;
            $display("FAIL stream status_udf got=%h exp=%h", d, 32'h0009_0000);
         end
      end
      wr(8'h00, 32'h8);
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      wr(8'h00, 32'h8);
      for (int i = 0; i < DEPTH + 1; i++) wr(8'h08, $urandom);
      rd(8'h0C, d);
      checks++;
      if (d !== (32'(DEPTH) | 32'h0006_0000)) begin
         failures++;
         $display("FAIL overflow status got=%h exp=%h", d, 32'(DEPTH) | 32'h0006_0000);
      end
      rd(8'h08, d);
      checks++;
      if (d !== 32'h0) begin
         failures++;
         $display("FAIL overflow data_read got=%h exp=0", d);
      end
      wr(8'h0C, 32'h0004_0000);
      rd(8'h0C, d);
      checks++;
      if (d !== (32'(DEPTH) | 32'h0002_0000)) begin
         failures++;
         $display("FAIL overflow w1c got=%h exp=%h", d, 32'(DEPTH) | 32'h0002_0000);
      end
      wr(8'h00, 32'h8);
      rd(8'h0C, d);
      checks++;
      if (d !== 32'h0001_0000) begin
         failures++;
         $display("FAIL overflow flush got=%h exp=%h", d, 32'h0001_0000);
      end
   endtask

   task automatic test_loop();
      logic [31:0] d;
      int n, ivl, per, M;
      for (int it = 0; it < 3; it++) begin
         wr(8'h00, 32'h8);
         q.delete();
         if (it == 0) begin
            ivl = 1; M = 10;
            q.push_back(16'h0100); q.push_back(16'h0200);
         end else begin
            ivl = $urandom_range(0, 3);
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) q.push_back(16'($urandom));
            M = 3 * n * period(ivl) + 2;
         end
         per = period(ivl);
         wr(8'h04, ivl);
         push_q();
         wr(8'h00, 32'h3);
         monitor("loop", per, 1'b1, M, 1'b0, 0, 32'h2);
         rd(8'h0C, d);
         checks++;
         if (d !== 32'(q.size())) begin
            failures++;
            $display("FAIL loop count got=%h exp=%h", d, q.size());
         end
         wr(8'h08, $urandom);
         rd(8'h0C, d);
         checks++;
         if (d !== (32'(q.size()) | 32'h0004_0000)) begin
            failures++;
            $display("FAIL loop push_drop got=%h exp=%h", d, 32'(q.size()) | 32'h0004_0000);
         end
      end
      wr(8'h00, 32'h8);
   endtask

   task automatic test_irq();
      logic [31:0] d;
      wr(8'h00, 32'h8);
      wr(8'h04, 32'd2);
      wr(8'h00, 32'h104);
      q.delete();
      for (int i = 0; i < 3; i++) q.push_back(16'($urandom));
      push_q();
      checks++;
      if (o_irq !== 1'b0) begin
         failures++;
         $display("FAIL irq after_fill got=%0b exp=0", o_irq);
      end
      wr(8'h00, 32'h105);
      monitor("irq", period(2), 1'b0, 5 * period(2) + 1, 1'b1, 1, 32'h104);
      push_q();
      checks++;
      if (o_irq !== 1'b0) begin
         failures++;
         $display("FAIL irq refill got=%0b exp=0", o_irq);
      end
      wr(8'h00, 32'h10C);
      checks++;
      if (o_irq !== 1'b0) begin
         failures++;
         $display("FAIL irq flush_lag got=%0b exp=0", o_irq);
      end
      @(negedge clk_i);
      checks++;
      if (o_irq !== 1'b1) begin
         failures++;
         $display("FAIL irq after_flush got=%0b exp=1", o_irq);
      end
      rd(8'h0C, d);
      checks++;
      if (d !== 32'h0001_0000) begin
         failures++;
         $display("FAIL irq flush_status got=%h exp=%h", d, 32'h0001_0000);
      end
      rd(8'h00, d);
      checks++;
      if (d !== 32'h0000_0104) begin
         failures++;
         $display("FAIL irq ctrl_readback got=%h exp=%h", d, 32'h0000_0104);
      end
      wr(8'h00, 32'h8);
   endtask

   // pushes arrive every cycle while a pop happens every cycle
   task automatic test_back_to_back();
      logic [31:0] d;
      bit ev;
      wr(8'h00, 32'h8);
      wr(8'h04, 32'd1);
      q.delete();
      for (int i = 0; i < 8; i++) q.push_back(16'($urandom));
      wr(8'h08, {16'd0, q[0]});
      wr(8'h08, {16'd0, q[1]});
      wr(8'h00, 32'h1);
      for (int j = 1; j <= 10; j++) begin
         ev = (j >= 2 && j <= 9);
         if (ev) exp_dc = q[j - 2];
         checks++;
         if (o_valid_DC !== ev) begin
            failures++;
            $display("FAIL b2b valid cycle=%0d got=%0b exp=%0b", j, o_valid_DC, ev);
         end
         checks++;
         if (o_DC !== exp_dc) begin
            failures++;
            $display("FAIL b2b dc cycle=%0d got=%h exp=%h", j, o_DC, exp_dc);
         end
         if (j == 5) begin
            rd(8'h0C, d);
            checks++;
            if (d !== 32'h2) begin
               failures++;
               $display("FAIL b2b count got=%h exp=2", d);
            end
         end
         if (j <= 6) begin
            we_i = 1'b1; addr_i = 8'h08; wdata_i = {16'd0, q[j + 1]};
         end
         if (j < 10) begin
            @(negedge clk_i);
            we_i = 1'b0;
         end
      end
      rd(8'h0C, d);
      checks++;
      if (d !== 32'h0009_0000) begin
         failures++;
         $display("FAIL b2b final_status got=%h exp=%h", d, 32'h0009_0000);
      end
      wr(8'h00, 32'h8);
   endtask

   task automatic test_prescale();
      logic [31:0] d;
      logic [31:0] exp_ps;
      wr(8'h00, 32'h8);
`ifdef PWM_DC_SEQ_PRESCALE_EN
      wr(8'h10, 32'd2);
      exp_ps = 32'd2;
      ps_val = 2;
`else
      wr(8'h10, 32'hFF);
      exp_ps = 32'd0;
      ps_val = 0;
`endif
      rd(8'h10, d);
      checks++;
      if (d !== exp_ps) begin
         failures++;
         $display("FAIL prescale readback got=%h exp=%h", d, exp_ps);
      end
      wr(8'h04, 32'd3);
      q.delete();
      for (int i = 0; i < 3; i++) q.push_back(16'($urandom));
      push_q();
      wr(8'h00, 32'h1);
      monitor("prescale", period(3), 1'b0, 5 * period(3) + 1, 1'b0, 0, 32'h0);
      wr(8'h00, 32'h8);
      wr(8'h10, 32'd0);
      ps_val = 0;
   endtask

   task automatic test_async_reset();
      logic [31:0] d;
      wr(8'h00, 32'h8);
      wr(8'h04, 32'd1);
      wr(8'h08, 32'h1234);
      wr(8'h08, 32'h5678);
      wr(8'h00, 32'h1);
      @(negedge clk_i);
      #2;
      rst_i = 1'b1;
      exp_dc = '0;
      #1;
      checks++;
      if (o_valid_DC !== 1'b0 || o_DC !== 16'h0 || o_irq !== 1'b0) begin
         failures++;
         $display("FAIL async_reset outputs got=%0b/%h/%0b exp=0/0000/0", o_valid_DC, o_DC, o_irq);
      end
      rd(8'h0C, d);
      checks++;
      if (d !== 32'h0001_0000) begin
         failures++;
         $display("FAIL async_reset status got=%h exp=%h", d, 32'h0001_0000);
      end
      rd(8'h00, d);
      checks++;
      if (d !== 32'h0) begin
         failures++;
         $display("FAIL async_reset ctrl got=%h exp=0", d);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_overflow();
      test_loop();
      test_irq();
      test_back_to_back();
      test_prescale();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
